// File: rtl/upg_loader.sv
// rtl/upg_loader.sv - byte-stream boot loader that frames UART bytes into instruction-memory word writes
module upg_loader #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned MAX_WORDS   = 16384,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  SYNC  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       sh_q, sh_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rst_q, rst_d;
  logic              active;
  logic [15:0]       len_rx;

  assign len_rx = {rx_data_i, len_lo_q};

  // Next-state and next-output computation for the framing FSM, including the inter-byte timeout.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    csum_d   = csum_q;
    tmo_d    = '0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    wen_d    = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    active   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
               (state_q == S_DATA)   || (state_q == S_CSUM);

    // The address advances the cycle after a write so it stays stable during the strobe.
    if (wen_q) begin
      adr_d = adr_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (rx_valid_i && (rx_data_i == SYNC)) begin
          state_d = S_LEN_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          adr_d   = '0;
          csum_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (rx_valid_i) begin
          len_lo_d = rx_data_i;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid_i) begin
          if ((len_rx == 16'd0) || (32'(len_rx) > MAX_WORDS)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            len_d   = len_rx;
            idx_d   = 2'd0;
            wcnt_d  = 16'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid_i) begin
          csum_d = csum_q ^ rx_data_i;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            dat_d = {rx_data_i, sh_q};
            wen_d = 1'b1;
            if (wcnt_q == (len_q - 16'd1)) begin
              state_d = S_CSUM;
            end else begin
              wcnt_d = wcnt_q + 16'd1;
            end
          end else begin
            sh_d[{idx_q, 3'b000} +: 8] = rx_data_i;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid_i) begin
          if (rx_data_i == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (active && !rx_valid_i) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    rst_d = !((state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
              (state_d == S_DATA)   || (state_d == S_CSUM));
  end

  // State and registered-output flops; reset drops every output immediately, mid-frame included.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      wen_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      wen_q    <= wen_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rst_q    <= rst_d;
    end
  end

  assign upg_rst_o  = rst_q;
  assign busy_o     = ~rst_q;
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_upg_loader.sv
// tb/tb_upg_loader.sv - self-checking bench for upg_loader against a frame-level model
module tb_upg_loader;

  localparam int ADDR_W  = 14;
  localparam int MAX_W   = 16384;
  localparam int TMO     = 100;

  logic              clk;
  logic              reset_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              upg_rst_o;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic              err_o;
  logic              busy_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [7:0]        frm[$];
  logic [ADDR_W-1:0] exp_adr[$];
  logic [31:0]       exp_dat[$];
  logic [ADDR_W-1:0] got_adr[$];
  logic [31:0]       got_dat[$];
  int                wen_cyc[$];
  logic              exp_done;
  logic              exp_err;

  upg_loader #(
    .ADDR_W(ADDR_W),
    .MAX_WORDS(MAX_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .upg_rst_o(upg_rst_o),
    .upg_wen_o(upg_wen_o),
    .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o),
    .err_o(err_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every cycle out of reset: busy mirrors the programmer reset, and each write matches the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy_vs_rst", busy_o, !upg_rst_o);
      if (upg_wen_o) begin
        wen_cyc.push_back(cyc);
        got_adr.push_back(upg_adr_o);
        got_dat.push_back(upg_dat_o);
        if (exp_adr.size() == 0) begin
          chk("unexpected_wen", 1, 0);
        end else begin
          chk("wr_adr", upg_adr_o, exp_adr.pop_front());
          chk("wr_dat", upg_dat_o, exp_dat.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic clr();
    got_adr.delete();
    got_dat.delete();
    wen_cyc.delete();
  endtask

  // Frame-level model: parse the complete byte list and derive writes and final outcome.
  task automatic model_frame();
    int         len;
    logic [7:0] cs;
    logic [31:0] w;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    cs       = 8'h00;
    len      = {frm[2], frm[1]};
    if (len == 0 || len > MAX_W) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      w = {frm[3+4*i+3], frm[3+4*i+2], frm[3+4*i+1], frm[3+4*i]};
      exp_adr.push_back(ADDR_W'(i));
      exp_dat.push_back(w);
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    if (frm[3+4*len] == cs) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic end_checks();
    chk("done", upg_done_o, exp_done);
    chk("err", err_o, exp_err);
    chk("upg_rst", upg_rst_o, 1);
    chk("busy", busy_o, 0);
    chk("writes_left", exp_adr.size(), 0);
  endtask

  task automatic run_frame();
    clr();
    model_frame();
    send_frm();
    end_checks();
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_upg_rst", upg_rst_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_wen", upg_wen_o, 0);
    chk("rst_done", upg_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_adr", upg_adr_o, 0);
    chk("rst_dat", upg_dat_o, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Stray byte in IDLE is ignored, then a good LEN=2 frame (XOR of data bytes is 0x44).
    send_byte(8'h3C);
    chk("idle_ignore_busy", busy_o, 0);
    frm = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    run_frame();
    @(negedge clk);
    chk("a_done_lit", upg_done_o, 1);
    chk("a_nwr", got_dat.size(), 2);
    if (got_dat.size() == 2) begin
      chk("a_w0_dat", got_dat[0], 32'h44332211);
      chk("a_w0_adr", got_adr[0], 0);
      chk("a_w1_dat", got_dat[1], 32'hDDCCBBAA);
      chk("a_w1_adr", got_adr[1], 1);
    end
    @(posedge clk);
    #1;

    // Same data, wrong checksum.
    frm[11] = 8'h01;
    run_frame();
    @(negedge clk);
    chk("b_err_lit", err_o, 1);
    chk("b_done_lit", upg_done_o, 0);
    chk("b_nwr", got_dat.size(), 2);
    @(posedge clk);
    #1;

    // Illegal lengths: zero and MAX_WORDS+1.
    frm = {8'hA5, 8'h00, 8'h00};
    run_frame();
    chk("len0_err_lit", err_o, 1);
    frm = {8'hA5, 8'h01, 8'h40};
    run_frame();
    chk("len16385_err_lit", err_o, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("badlen_nwr", got_dat.size(), 0);

    // Timeout after two data bytes of a LEN=1 frame.
    clr();
    frm = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_frm();
    chk("tmo_busy", busy_o, 1);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (err_o) begin
        n = i;
        break;
      end
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_done", upg_done_o, 0);
    chk("tmo_busy_after", busy_o, 0);
    chk("tmo_nwr", got_dat.size(), 0);

    // A byte landing on the expiry cycle wins over the timeout.
    clr();
    frm = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    model_frame();
    for (int i = 0; i < 3; i++) send_byte(frm[i]);
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("win_err_pre", err_o, 0);
    send_byte(frm[3]);
    chk("win_err", err_o, 0);
    chk("win_busy", busy_o, 1);
    for (int i = 4; i < 8; i++) send_byte(frm[i]);
    end_checks();

    // Back-to-back LEN=4 frame.
    frm = {8'hA5, 8'h04, 8'h00};
    begin
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'h00;
      for (int i = 0; i < 16; i++) begin
        b = 8'(i * 37 + 5);
        frm.push_back(b);
        cs = cs ^ b;
      end
      frm.push_back(cs);
    end
    run_frame();
    @(negedge clk);
    chk("b2b_nwr", wen_cyc.size(), 4);
    if (wen_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_space", wen_cyc[i] - wen_cyc[i-1], 4);
    end
    @(posedge clk);
    #1;

    // Reset during DATA, landing on a write strobe, then a fresh frame.
    clr();
    frm = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    model_frame();
    for (int i = 0; i < 7; i++) send_byte(frm[i]);
    chk("mid_wen", upg_wen_o, 1);
    chk("mid_adr", upg_adr_o, 0);
    chk("mid_dat", upg_dat_o, 32'h44332211);
    void'(exp_adr.pop_front());
    void'(exp_dat.pop_front());
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wen", upg_wen_o, 0);
    chk("mid_rst_upg_rst", upg_rst_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", upg_done_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_adr", upg_adr_o, 0);
    chk("mid_rst_dat", upg_dat_o, 0);
    exp_adr.delete();
    exp_dat.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame();
    @(negedge clk);
    chk("re_nwr", got_dat.size(), 2);
    if (got_adr.size() == 2) chk("re_first_adr", got_adr[0], 0);
    chk("re_done_lit", upg_done_o, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
